branch_history_cache: RTL and testbench

//  Parametrised, set-associative per-branch history cache for the pipeline fetch stage.

---
 rtl/bhc_pkg.sv | 40 ++++
 rtl/bhc_set.sv | 109 ++++++++++
 rtl/branch_history_cache.sv | 90 +++++++++
 tb/tb_branch_history_cache.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bhc_pkg.sv
// Shared types and helpers for the branch history cache.
// Entry layout gains a 2-bit saturating counter when SAT_CNT_EN is defined.
package bhc_pkg;

    // Entry fields are sized for the widest supported configuration.
    // Unused upper bits stay zero.
    localparam int BHC_TAG_MAX  = 32;
    localparam int BHC_HIST_MAX = 16;

    localparam logic [1:0] CNT_INIT       = 2'b01;
    localparam logic [1:0] CNT_TAKEN_INIT = 2'b10;

    typedef struct packed {
        logic                    valid;
        logic [BHC_TAG_MAX-1:0]  tag;
        logic [BHC_HIST_MAX-1:0] history;
`ifdef SAT_CNT_EN
        logic [1:0]              cnt;
`endif
    } bhc_entry_t;

    function automatic int bhc_tag_w(input int pc_w, input int idx_w);
        return pc_w - idx_w;
    endfunction

    // Ties predict taken, so an even split counts as a majority of ones.
    function automatic logic bhc_majority(input logic [BHC_HIST_MAX-1:0] history,
                                          input int unsigned width);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < BHC_HIST_MAX; i++) ones = ones + 32'(history[i]);
        return (2 * ones) >= width;
    endfunction

    function automatic logic [1:0] bhc_sat_step(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bhc_set.sv
// One set of the branch history cache: WAYS entries, LRU bit, tag compare, victim select.
// Counter storage is present only when SAT_CNT_EN is defined.
module bhc_set
    import bhc_pkg::*;
#(
    parameter int TAG_W  = 6,
    parameter int HIST_W = 3,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              lk_hit,
    output logic [HIST_W-1:0] lk_history,
    output logic              lk_predict,
    input  logic              upd_en,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic              upd_taken,
    output logic              evict,
    output logic [TAG_W-1:0]  evict_tag
);

    localparam logic [BHC_HIST_MAX-1:0] HIST_MASK = {BHC_HIST_MAX{1'b1}} >> (BHC_HIST_MAX - HIST_W);

    bhc_entry_t ways_q [WAYS];
    logic       lru_q;
    logic       upd_hit;
    logic       upd_way;
    logic       victim;
    logic       victim_valid;

    // Reads see only the registered array, so a same-cycle update is never bypassed.
    always_comb begin
        lk_hit       = 1'b0;
        lk_history   = '0;
        lk_predict   = 1'b0;
        upd_hit      = 1'b0;
        upd_way      = 1'b0;
        victim_valid = 1'b0;
        evict_tag    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ways_q[w].valid && (ways_q[w].tag == BHC_TAG_MAX'(lk_tag))) begin
                lk_hit     = 1'b1;
                lk_history = ways_q[w].history[HIST_W-1:0];
`ifdef SAT_CNT_EN
                lk_predict = ways_q[w].cnt[1];
`else
                lk_predict = bhc_majority(ways_q[w].history, HIST_W);
`endif
            end
            if (ways_q[w].valid && (ways_q[w].tag == BHC_TAG_MAX'(upd_tag))) begin
                upd_hit = 1'b1;
                upd_way = w[0];
            end
        end
        if (!ways_q[0].valid)           victim = 1'b0;
        else if (!ways_q[WAYS-1].valid) victim = 1'b1;
        else                            victim = lru_q;
        for (int w = 0; w < WAYS; w++) begin
            if (victim == w[0]) begin
                victim_valid = ways_q[w].valid;
                evict_tag    = ways_q[w].tag[TAG_W-1:0];
            end
        end
        evict = upd_en && !flush && !upd_hit && victim_valid;
    end

    // NOTE: the entry array takes the async reset too, so valid bits are known without a clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                ways_q[w] <= '0;
`ifdef SAT_CNT_EN
                ways_q[w].cnt <= CNT_INIT;
`endif
            end
        end else if (flush) begin
            for (int w = 0; w < WAYS; w++) ways_q[w].valid <= 1'b0;
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (upd_hit && (upd_way == w[0])) begin
                    ways_q[w].history <= ((ways_q[w].history << 1) | BHC_HIST_MAX'(upd_taken)) & HIST_MASK;
`ifdef SAT_CNT_EN
                    ways_q[w].cnt <= bhc_sat_step(ways_q[w].cnt, upd_taken);
`endif
                end else if (!upd_hit && (victim == w[0])) begin
                    ways_q[w].valid   <= 1'b1;
                    ways_q[w].tag     <= BHC_TAG_MAX'(upd_tag);
                    ways_q[w].history <= BHC_HIST_MAX'(upd_taken);
`ifdef SAT_CNT_EN
                    ways_q[w].cnt <= upd_taken ? CNT_TAKEN_INIT : CNT_INIT;
`endif
                end
            end
        end
    end

    if (WAYS == 2) begin : g_lru
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        lru_q <= 1'b0;
            else if (flush)  lru_q <= 1'b0;
            else if (upd_en) lru_q <= upd_hit ? ~upd_way : ~victim;
        end
    end else begin : g_no_lru
        assign lru_q = 1'b0;
    end

endmodule

// File: rtl/branch_history_cache.sv
// Set-associative per-branch history cache: index decode, registered lookup, evict reporting.
// Define SAT_CNT_EN to predict from a 2-bit saturating counter instead of history majority.
module branch_history_cache
    import bhc_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int IDX_W  = 4,
    parameter int WAYS   = 2,
    parameter int HIST_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         lk_valid,
    input  logic [PC_W-1:0]              lk_pc,
    output logic                         lk_hit,
    output logic [HIST_W-1:0]            lk_history,
    output logic                         lk_predict,
    input  logic                         upd_valid,
    input  logic [PC_W-1:0]              upd_pc,
    input  logic                         upd_taken,
    output logic                         evict,
    output logic [bhc_tag_w(PC_W,IDX_W)-1:0] evict_tag,
    output logic [IDX_W-1:0]             evict_index
);

    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = bhc_tag_w(PC_W, IDX_W);

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("branch_history_cache: WAYS must be 1 or 2");
    end
    if (HIST_W < 2 || HIST_W > BHC_HIST_MAX || TAG_W < 1 || TAG_W > BHC_TAG_MAX) begin : g_bad_width
        $error("branch_history_cache: HIST_W or TAG_W out of range");
    end

    logic [IDX_W-1:0]  lk_index, upd_index;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              set_upd   [SETS];
    logic              set_hit   [SETS];
    logic [HIST_W-1:0] set_hist  [SETS];
    logic              set_pred  [SETS];
    logic              set_evict [SETS];
    logic [TAG_W-1:0]  set_etag  [SETS];

    assign lk_index  = lk_pc[IDX_W-1:0];
    assign lk_tag    = lk_pc[PC_W-1:IDX_W];
    assign upd_index = upd_pc[IDX_W-1:0];
    assign upd_tag   = upd_pc[PC_W-1:IDX_W];

    for (genvar s = 0; s < SETS; s++) begin : g_set
        assign set_upd[s] = upd_valid && (upd_index == IDX_W'(s));
        bhc_set #(.TAG_W(TAG_W), .HIST_W(HIST_W), .WAYS(WAYS)) u_set (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .lk_tag     (lk_tag),
            .lk_hit     (set_hit[s]),
            .lk_history (set_hist[s]),
            .lk_predict (set_pred[s]),
            .upd_en     (set_upd[s]),
            .upd_tag    (upd_tag),
            .upd_taken  (upd_taken),
            .evict      (set_evict[s]),
            .evict_tag  (set_etag[s])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_hit      <= 1'b0;
            lk_history  <= '0;
            lk_predict  <= 1'b0;
            evict       <= 1'b0;
            evict_tag   <= '0;
            evict_index <= '0;
        end else begin
            lk_hit     <= lk_valid && set_hit[lk_index];
            lk_history <= lk_valid ? set_hist[lk_index] : '0;
            lk_predict <= lk_valid && set_pred[lk_index];
            evict      <= set_evict[upd_index];
            // Victim identity is held until the next eviction overwrites it.
            if (set_evict[upd_index]) begin
                evict_tag   <= set_etag[upd_index];
                evict_index <= upd_index;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_cache.sv
// Self-checking bench for branch_history_cache: directed scenarios plus randomized traffic
// against a recency-ordered queue model of each set.
module tb_branch_history_cache;

    localparam int PC_W   = 10;
    localparam int IDX_W  = 4;
    localparam int WAYS   = 2;
    localparam int HIST_W = 3;
    localparam int SETS   = 1 << IDX_W;
    localparam int TAG_W  = PC_W - IDX_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              lk_valid = 1'b0;
    logic [PC_W-1:0]   lk_pc = '0;
    logic              lk_hit;
    logic [HIST_W-1:0] lk_history;
    logic              lk_predict;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic              evict;
    logic [TAG_W-1:0]  evict_tag;
    logic [IDX_W-1:0]  evict_index;

    always #5 clk = ~clk;

    branch_history_cache #(.PC_W(PC_W), .IDX_W(IDX_W), .WAYS(WAYS), .HIST_W(HIST_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_hit(lk_hit), .lk_history(lk_history), .lk_predict(lk_predict),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .evict(evict), .evict_tag(evict_tag), .evict_index(evict_index)
    );

    // Each set is a queue ordered least- to most-recently updated.
    typedef struct {
        int unsigned tag;
        int unsigned hist;
        int          cnt;
    } m_ent_t;

    m_ent_t m_set [SETS][$];

    int n_tests = 0;
    int n_fail  = 0;

    logic              exp_hit, exp_pred, exp_evict;
    logic [HIST_W-1:0] exp_hist;
    logic [TAG_W-1:0]  exp_etag;
    logic [IDX_W-1:0]  exp_eidx;

    function automatic logic m_predict(input m_ent_t e);
`ifdef SAT_CNT_EN
        return e.cnt >= 2;
`else
        int ones = 0;
        for (int i = 0; i < HIST_W; i++) ones += (e.hist >> i) & 1;
        return 2 * ones >= HIST_W;
`endif
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) m_set[s].delete();
        exp_evict = 1'b0;
        exp_etag  = '0;
        exp_eidx  = '0;
    endtask

    task automatic model_lookup(input logic [PC_W-1:0] pc);
        int          idx = int'(pc[IDX_W-1:0]);
        int unsigned tag = int'(pc[PC_W-1:IDX_W]);
        for (int k = 0; k < m_set[idx].size(); k++) begin
            if (m_set[idx][k].tag == tag) begin
                exp_hit  = 1'b1;
                exp_hist = HIST_W'(m_set[idx][k].hist);
                exp_pred = m_predict(m_set[idx][k]);
            end
        end
    endtask

    task automatic model_update(input logic [PC_W-1:0] pc, input logic taken);
        int          idx = int'(pc[IDX_W-1:0]);
        int unsigned tag = int'(pc[PC_W-1:IDX_W]);
        int          found = -1;
        m_ent_t      e;
        for (int k = 0; k < m_set[idx].size(); k++)
            if (m_set[idx][k].tag == tag) found = k;
        if (found >= 0) begin
            e = m_set[idx][found];
            e.hist = ((e.hist * 2) + int'(taken)) % (1 << HIST_W);
            e.cnt  = taken ? ((e.cnt == 3) ? 3 : e.cnt + 1) : ((e.cnt == 0) ? 0 : e.cnt - 1);
            m_set[idx].delete(found);
            m_set[idx].push_back(e);
        end else begin
            if (m_set[idx].size() == WAYS) begin
                e = m_set[idx].pop_front();
                exp_evict = 1'b1;
                exp_etag  = TAG_W'(e.tag);
                exp_eidx  = IDX_W'(idx);
            end
            e.tag  = tag;
            e.hist = int'(taken);
            e.cnt  = taken ? 2 : 1;
            m_set[idx].push_back(e);
        end
    endtask

    // Expectations come from the pre-edge model state, then the model advances.
    task automatic do_cycle(input logic lv, input logic [PC_W-1:0] lpc, input logic uv,
                            input logic [PC_W-1:0] upc, input logic ut, input logic fl);
        exp_hit   = 1'b0;
        exp_hist  = '0;
        exp_pred  = 1'b0;
        exp_evict = 1'b0;
        if (lv) model_lookup(lpc);
        if (fl) for (int s = 0; s < SETS; s++) m_set[s].delete();
        else if (uv) model_update(upc, ut);
        lk_valid  = lv;
        lk_pc     = lpc;
        upd_valid = uv;
        upd_pc    = upc;
        upd_taken = ut;
        flush     = fl;
        @(posedge clk);
        #1;
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b %b %b %b %h %h, want all zero",
                     lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index);
        end
        #10 rst = 1'b1;
        model_reset();
        do_cycle(1'b1, 10'h025, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, lk_predict, evict} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_lookup_miss: got hit=%b hist=%b pred=%b evict=%b, want 0 000 0 0",
                     lk_hit, lk_history, lk_predict, evict);
        end
    endtask

    task automatic test_taken_history();
        for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, 10'h025, 1'b1, 1'b0);
        do_cycle(1'b1, 10'h025, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, lk_predict, evict} !== 6'b1_111_1_0) begin
            n_fail++;
            $display("FAIL taken_x3: got hit=%b hist=%b pred=%b evict=%b, want 1 111 1 0",
                     lk_hit, lk_history, lk_predict, evict);
        end
    endtask

    task automatic test_eviction();
        do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b1, 10'h015, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 10'h025, 1'b1, 1'b0);
        n_tests++;
        if (evict !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_no_evict: got evict=%b, want 0", evict);
        end
        do_cycle(1'b0, '0, 1'b1, 10'h035, 1'b1, 1'b0);
        n_tests++;
        if ({evict, evict_tag, evict_index} !== {1'b1, 6'd1, 4'd5}) begin
            n_fail++;
            $display("FAIL lru_evict: got evict=%b tag=%0d idx=%0d, want 1 1 5",
                     evict, evict_tag, evict_index);
        end
        do_cycle(1'b1, 10'h025, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, evict, evict_tag} !== {1'b1, 3'b001, 1'b0, 6'd1}) begin
            n_fail++;
            $display("FAIL survivor_hit: got hit=%b hist=%b evict=%b tag=%0d, want 1 001 0 1",
                     lk_hit, lk_history, evict, evict_tag);
        end
        do_cycle(1'b1, 10'h015, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (lk_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL evicted_miss: got hit=%b, want 0", lk_hit);
        end
    endtask

    task automatic test_same_cycle();
        logic pred_old;
`ifdef SAT_CNT_EN
        pred_old = 1'b1;
`else
        pred_old = 1'b0;
`endif
        do_cycle(1'b1, 10'h025, 1'b1, 10'h025, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, lk_predict} !== {1'b1, 3'b001, pred_old}) begin
            n_fail++;
            $display("FAIL same_cycle_old: got hit=%b hist=%b pred=%b, want 1 001 %b",
                     lk_hit, lk_history, lk_predict, pred_old);
        end
        do_cycle(1'b1, 10'h025, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, lk_predict} !== 5'b1_010_0) begin
            n_fail++;
            $display("FAIL same_cycle_new: got hit=%b hist=%b pred=%b, want 1 010 0",
                     lk_hit, lk_history, lk_predict);
        end
    endtask

    task automatic test_flush();
        logic [PC_W-1:0] pcs [3];
        pcs = '{10'h025, 10'h035, 10'h045};
        do_cycle(1'b1, 10'h035, 1'b1, 10'h045, 1'b1, 1'b1);
        n_tests++;
        if ({lk_hit, lk_history, evict, evict_tag, evict_index} !== {1'b1, 3'b001, 1'b0, 6'd1, 4'd5}) begin
            n_fail++;
            $display("FAIL flush_same_cycle: got hit=%b hist=%b evict=%b tag=%0d idx=%0d, want 1 001 0 1 5",
                     lk_hit, lk_history, evict, evict_tag, evict_index);
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, pcs[i], 1'b0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({lk_hit, lk_history, lk_predict} !== 5'b0) begin
                n_fail++;
                $display("FAIL flush_miss_%0d: got hit=%b hist=%b pred=%b, want 0 000 0",
                         i, lk_hit, lk_history, lk_predict);
            end
        end
        do_cycle(1'b0, '0, 1'b1, 10'h045, 1'b1, 1'b0);
        do_cycle(1'b1, 10'h045, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({lk_hit, lk_history, evict} !== 5'b1_001_0) begin
            n_fail++;
            $display("FAIL flush_realloc: got hit=%b hist=%b evict=%b, want 1 001 0",
                     lk_hit, lk_history, evict);
        end
    endtask

    task automatic test_predict();
`ifdef SAT_CNT_EN
        logic seq_t [9];
        logic seq_p [9];
        seq_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        seq_p = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        logic seq_t [5];
        logic seq_p [5];
        seq_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        seq_p = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < $size(seq_t); i++) begin
            do_cycle(1'b0, '0, 1'b1, 10'h033, seq_t[i], 1'b0);
            do_cycle(1'b1, 10'h033, 1'b0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({lk_hit, lk_predict} !== {1'b1, seq_p[i]}) begin
                n_fail++;
                $display("FAIL predict_step_%0d: got hit=%b pred=%b, want 1 %b",
                         i, lk_hit, lk_predict, seq_p[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b1, 10'h015, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 10'h025, 1'b1, 1'b0);
        do_cycle(1'b1, 10'h025, 1'b1, 10'h035, 1'b1, 1'b0);
        n_tests++;
        if ({lk_hit, evict} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_state: got hit=%b evict=%b, want 1 1", lk_hit, evict);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %b %b %b %b %h %h, want all zero",
                     lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        do_cycle(1'b1, 10'h025, 1'b0, '0, 1'b0, 1'b0);
        n_tests++;
        if (lk_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_miss: got hit=%b, want 0", lk_hit);
        end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] lpc, upc;
        int              sets [3];
        sets = '{5, 6, 9};
        for (int i = 0; i < 400; i++) begin
            lpc = {TAG_W'($urandom_range(0, 3)), IDX_W'(sets[$urandom_range(0, 2)])};
            upc = {TAG_W'($urandom_range(0, 3)), IDX_W'(sets[$urandom_range(0, 2)])};
            do_cycle(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
                     1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
            n_tests++;
            if ({lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index} !==
                {exp_hit, exp_hist, exp_pred, exp_evict, exp_etag, exp_eidx}) begin
                n_fail++;
                $display("FAIL random_%0d: got hit=%b hist=%b pred=%b ev=%b tag=%0d idx=%0d, want %b %b %b %b %0d %0d",
                         i, lk_hit, lk_history, lk_predict, evict, evict_tag, evict_index,
                         exp_hit, exp_hist, exp_pred, exp_evict, exp_etag, exp_eidx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_taken_history();
        test_eviction();
        test_same_cycle();
        test_flush();
        test_predict();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
